// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch front end: width defaults,
// the buffered {pc, inst} entry type and counter-width helper.
package ifu_pkg;

  localparam int unsigned IFU_XLEN    = 32;
  localparam int unsigned IFU_PC_STEP = 4;
  localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = '0;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_XLEN-1:0] inst;
  } ifu_entry_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous first-word-fall-through queue. The head is held in its own register so an
// empty queue keeps presenting the last head value.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned LW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [LW-1:0]    level_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    rptr_inc;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign rptr_inc = rptr_q + PW'(1);
  assign do_push  = push_i && !flush_i && (count_q != LW'(DEPTH));
  assign do_pop   = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_inc;
      count_d = count_q + LW'(do_push) - LW'(do_pop);
      // Next head: the incoming word when it lands at the front, else the slot behind the head.
      if ((count_q == '0) || (do_pop && (count_q == LW'(1)))) begin
        if (do_push) head_d = wdata_i;
      end else if (do_pop) begin
        head_d = mem_q[rptr_inc];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = head_q;
  assign valid_o = (count_q != '0);
  assign level_o = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: issues credit-limited requests on the external instruction port,
// buffers in-order responses with their PCs and redirects on a branch.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned      XLEN     = IFU_XLEN,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IFU_RESET_PC),
  parameter int unsigned      PC_STEP  = IFU_PC_STEP,
  localparam int unsigned     LW       = cnt_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_en,
  input  logic [XLEN-1:0] br_addr,
  output logic            exIns_ren,
  output logic [XLEN-1:0] exIns_addr,
  input  logic            exIns_valid,
  input  logic [XLEN-1:0] exIns_in,
  output logic            ins_valid,
  output logic [XLEN-1:0] ins_out,
  output logic [XLEN-1:0] pc,
  output logic [LW-1:0]   level
);

  localparam logic [XLEN-1:0] PcInc  = XLEN'(PC_STEP);
  localparam logic [LW:0]     DepthW = (LW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [LW-1:0]   outst_q, outst_d;
  logic [LW-1:0]   drop_q, drop_d;

  logic            issue, resp, push, pop;
  logic [LW:0]     credit_used;
  logic [XLEN-1:0] target;

  // Queued words plus requests in flight never exceed DEPTH, so a response always has a slot.
  assign credit_used = {1'b0, level} + {1'b0, outst_q};
  assign issue       = !rst && !br_en && (credit_used < DepthW);
  assign resp        = exIns_valid && (outst_q != '0);
  assign push        = resp && (drop_q == '0) && !br_en;
  assign pop         = ins_valid && !stall;
  assign target      = {br_addr[XLEN-1:2], 2'b00};

  assign exIns_ren  = issue;
  assign exIns_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (br_en) begin
      // Everything still in flight (minus this cycle's response) belongs to the old stream.
      fetch_pc_d = target;
      resp_pc_d  = target;
      drop_d     = outst_q - LW'(resp);
      outst_d    = outst_q - LW'(resp);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PcInc;
      if (push)  resp_pc_d  = resp_pc_q + PcInc;
      outst_d = outst_q + LW'(issue) - LW'(resp);
      if (resp && (drop_q != '0)) drop_d = drop_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (br_en),
    .wdata_i ({resp_pc_q, exIns_in}),
    .rdata_o ({pc, ins_out}),
    .valid_o (ins_valid),
    .level_o (level)
  );

  // A response with nothing in flight is a memory-side protocol violation.
  assert property (@(posedge clk) disable iff (rst) exIns_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: in-order memory model with configurable latency, a queue-based
// reference of the fetch stream, a directed vector table and hand-written corner sequences.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br_en, exIns_valid;
  logic [31:0] br_addr, exIns_in;
  logic        exIns_ren, ins_valid;
  logic [31:0] exIns_addr, ins_out, pc;
  logic [2:0]  level;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_en       (br_en),
    .br_addr     (br_addr),
    .exIns_ren   (exIns_ren),
    .exIns_addr  (exIns_addr),
    .exIns_valid (exIns_valid),
    .exIns_in    (exIns_in),
    .ins_valid   (ins_valid),
    .ins_out     (ins_out),
    .pc          (pc),
    .level       (level)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic        stall;
    logic        ren;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    int          lvl;
  } vec_t;

  req_t        pending[$];
  ifu_entry_t  q[$];
  vec_t        tbl[20];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fix_lat = 1;
  bit rand_lat = 1'b0;
  bit model_ok = 1'b0;
  int pend_start;

  int          m_outst, m_drop;
  logic [31:0] m_fetch, m_resp;
  ifu_entry_t  m_head;

  logic        s_ren, s_valid;
  logic [31:0] s_addr, s_pc, s_ins;
  logic [2:0]  s_level;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs and memory response, sample, compare against the model, advance it.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] ba);
    bit          exp_ren, rv;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    cyc++;
    rst = r; stall = s; br_en = b; br_addr = ba;
    pend_start  = pending.size();
    exIns_valid = 1'b0;
    exIns_in    = '0;
    if (r) begin
      pending.delete();
    end else if (pending.size() > 0 && pending[0].due <= cyc) begin
      exIns_valid = 1'b1;
      exIns_in    = pending[0].addr ^ KEY;
      void'(pending.pop_front());
    end
    @(negedge clk);
    s_ren = exIns_ren; s_addr = exIns_addr; s_valid = ins_valid;
    s_pc = pc; s_ins = ins_out; s_level = level;

    exp_ren = !r && !b && (q.size() + m_outst < DEPTH);
    if (model_ok) begin
      chk("ren", s_ren, exp_ren);
      if (exp_ren) chk("addr", s_addr, m_fetch);
      chk("ins_valid", s_valid, q.size() != 0);
      chk("level", s_level, q.size());
      chk("pc", s_pc, m_head.pc);
      chk("ins_out", s_ins, m_head.inst);
      if (!r) chk("credit_bound", (int'(s_level) + pend_start) <= DEPTH, 1'b1);
    end
    if (s_ren) pending.push_back('{addr: s_addr, due: cyc + (rand_lat ? int'($urandom_range(5, 1)) : fix_lat)});

    rv  = exIns_valid && (m_outst > 0);
    tgt = {ba[31:2], 2'b00};
    if (r) begin
      q.delete();
      m_outst = 0; m_drop = 0; m_fetch = '0; m_resp = '0; m_head = '0;
      model_ok = 1'b1;
    end else if (b) begin
      q.delete();
      m_drop  = m_outst - int'(rv);
      m_outst = m_drop;
      m_fetch = tgt;
      m_resp  = tgt;
    end else begin
      if (q.size() > 0 && !s) void'(q.pop_front());
      if (rv) begin
        m_outst--;
        if (m_drop > 0) m_drop--;
        else begin
          q.push_back('{pc: m_resp, inst: exIns_in});
          m_resp += 32'd4;
        end
      end
      if (exp_ren) begin
        m_outst++;
        m_fetch += 32'd4;
      end
      if (q.size() > 0) m_head = q[0];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; br_en = 1'b0; br_addr = '0; exIns_valid = 1'b0; exIns_in = '0;

    // Sequential fetch (1-cycle memory), then 10-cycle stall and release.
    tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  0};
    tbl[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0,  0};
    tbl[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0,  1};
    tbl[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4,  1};
    tbl[4]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8,  1};
    tbl[5]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 1};
    tbl[6]  = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12, 2};
    tbl[7]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12, 3};
    for (int i = 8; i < 15; i++) tbl[i] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd12, 4};
    tbl[15] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd12, 4};
    tbl[16] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd16, 3};
    tbl[17] = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd20, 2};
    tbl[18] = '{1'b0, 1'b1, 32'd36, 1'b1, 32'd24, 2};
    tbl[19] = '{1'b0, 1'b1, 32'd40, 1'b1, 32'd28, 2};

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("rst_ren", s_ren, 1'b0);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_level", s_level, 3'd0);
    chk("rst_pc", s_pc, 32'd0);
    chk("rst_ins", s_ins, 32'd0);

    fix_lat = 1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, tbl[i].stall, 1'b0, '0);
      chk($sformatf("tbl%0d_ren", i), s_ren, tbl[i].ren);
      if (tbl[i].ren) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_ins", i), s_ins, tbl[i].pc ^ KEY);
      end
      chk($sformatf("tbl%0d_level", i), s_level, tbl[i].lvl);
    end

    // Reset mid-stream with three words queued.
    n = 0;
    while (s_level != 3'd3 && n < 8) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      n++;
    end
    chk("mid_level3", s_level, 3'd3);
    fix_lat = 3;
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("mid_rst_valid", s_valid, 1'b0);
    chk("mid_rst_level", s_level, 3'd0);
    chk("mid_rst_ren", s_ren, 1'b1);
    chk("mid_rst_addr", s_addr, 32'd0);

    // Branch with three requests in flight on a 3-cycle memory.
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'h103);
    chk("br_ren", s_ren, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("br_level0", s_level, 3'd0);
    chk("br_ren_tgt", s_ren, 1'b1);
    chk("br_addr_tgt", s_addr, 32'h100);
    n = 0;
    while (!s_valid && n < 10) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      n++;
    end
    chk("br_wait", n, 4);
    chk("br_pc", s_pc, 32'h100);
    chk("br_ins", s_ins, 32'h100 ^ KEY);

    // Branch coinciding with a response, queue non-empty, no stall.
    fix_lat = 1;
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'h2001);
    chk("brv_level_before", s_level, 3'd1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("brv_level0", s_level, 3'd0);
    chk("brv_ren", s_ren, 1'b1);
    chk("brv_addr", s_addr, 32'h2000);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("brv_valid_t2", s_valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("brv_pc", s_pc, 32'h2000);
    chk("brv_valid_t3", s_valid, 1'b1);

    // Random stall / branch / reset with 1..5 cycle memory latency.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 300) == 0, ($urandom % 10) < 3, ($urandom % 25) == 0, $urandom);
    end
    rand_lat = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
